// File: rtl/divider_controller.sv
// Programmable clock-enable generator: one-cycle tick on the last cycle of each period plus a divided square wave.
// Latency: start is seen one cycle after enable is sampled; ratio and stop requests take effect on the next period boundary.
// Backpressure: cfg_ready drops while a ratio is pending mid-period and returns in the cycle after the boundary that applies it.
module divider_controller #(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 100
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             tick,
    output logic             clk_out,
    output logic [DIV_W-1:0] cur_div,
    output logic             running
);

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        RUN     = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0] DIV_DEF = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_TWO = DIV_W'(2);

    state_t           state;
    state_t           state_n;
    logic [DIV_W-1:0] p;
    logic [DIV_W-1:0] p_n;
    logic [DIV_W-1:0] cur_div_n;
    logic [DIV_W-1:0] pend_div;
    logic [DIV_W-1:0] pend_div_n;
    logic             cfg_ready_n;
    logic             cfg_err_n;
    logic             xfer;
    logic             cfg_ok;
    logic             boundary;
    logic             run_n;

    // cfg_ready low is the only record of a pending ratio; it clears whenever pend_div is consumed.
    always_comb begin
        xfer        = cfg_valid && cfg_ready;
        cfg_ok      = (cfg_div >= DIV_TWO);
        boundary    = (state != STOPPED) && (p == (cur_div - DIV_ONE));
        state_n     = state;
        p_n         = p;
        cur_div_n   = cur_div;
        pend_div_n  = pend_div;
        cfg_ready_n = cfg_ready;
        cfg_err_n   = xfer && !cfg_ok;

        case (state)
            STOPPED: begin
                p_n = '0;
                if (xfer && cfg_ok) begin
                    cur_div_n = cfg_div;
                end
                if (enable) begin
                    state_n = RUN;
                end
            end
            RUN, DRAIN: begin
                if (boundary) begin
                    p_n     = '0;
                    state_n = enable ? RUN : STOPPED;
                    if (!cfg_ready) begin
                        cur_div_n   = pend_div;
                        cfg_ready_n = 1'b1;
                    end else if (xfer && cfg_ok) begin
                        // A ratio arriving on the boundary misses this one; when stopping there is no later boundary.
                        if (enable) begin
                            pend_div_n  = cfg_div;
                            cfg_ready_n = 1'b0;
                        end else begin
                            cur_div_n = cfg_div;
                        end
                    end
                end else begin
                    p_n     = p + DIV_ONE;
                    state_n = enable ? RUN : DRAIN;
                    if (xfer && cfg_ok) begin
                        pend_div_n  = cfg_div;
                        cfg_ready_n = 1'b0;
                    end
                end
            end
            default: begin
                state_n = STOPPED;
                p_n     = '0;
            end
        endcase

        run_n = (state_n != STOPPED);
    end

    always_ff @(posedge clk_in) begin
        if (!rst) begin
            state     <= STOPPED;
            p         <= '0;
            cur_div   <= DIV_DEF;
            pend_div  <= '0;
            cfg_ready <= 1'b1;
            cfg_err   <= 1'b0;
            tick      <= 1'b0;
            clk_out   <= 1'b0;
            running   <= 1'b0;
        end else begin
            state     <= state_n;
            p         <= p_n;
            cur_div   <= cur_div_n;
            pend_div  <= pend_div_n;
            cfg_ready <= cfg_ready_n;
            cfg_err   <= cfg_err_n;
            tick      <= run_n && (p_n == (cur_div_n - DIV_ONE));
            clk_out   <= run_n && (p_n < (cur_div_n >> 1));
            running   <= run_n;
        end
    end

endmodule

// File: tb/tb_divider_controller.sv
// Directed bench for divider_controller: default run, reprogramming, rejects, drain/resume and reset.
module tb_divider_controller;

    logic        clk_in = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [15:0] cfg_div = 16'd0;
    logic        cfg_ready;
    logic        cfg_err;
    logic        tick;
    logic        clk_out;
    logic [15:0] cur_div;
    logic        running;

    int checks = 0;
    int errors = 0;

    divider_controller #(.DIV_W(16), .DEFAULT_DIV(100)) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .enable   (enable),
        .cfg_valid(cfg_valid),
        .cfg_div  (cfg_div),
        .cfg_ready(cfg_ready),
        .cfg_err  (cfg_err),
        .tick     (tick),
        .clk_out  (clk_out),
        .cur_div  (cur_div),
        .running  (running)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Inputs change and outputs are observed at the falling edge.
    task automatic step();
        @(negedge clk_in);
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        enable    = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = 16'd0;
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({tick, clk_out, running, cfg_err, cfg_ready} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 00001", {tick, clk_out, running, cfg_err, cfg_ready});
        end
        checks++;
        if (cur_div !== 16'd100) begin
            errors++;
            $display("FAIL reset_cur_div: got %0d required 100", cur_div);
        end
    endtask

    task automatic test_default_run();
        logic [2:0] exp;
        do_reset();
        enable = 1'b1;
        step();
        for (int k = 0; k < 300; k++) begin
            exp = {1'b1, (k % 100) == 99, (k % 100) < 50};
            checks++;
            if ({running, tick, clk_out} !== exp) begin
                errors++;
                $display("FAIL default_wave k=%0d: got %b required %b", k, {running, tick, clk_out}, exp);
            end
            if (k == 0) begin
                checks++;
                if (cur_div !== 16'd100) begin
                    errors++;
                    $display("FAIL default_cur_div: got %0d required 100", cur_div);
                end
            end
            step();
        end
    endtask

    task automatic test_div5();
        logic [2:0] exp;
        do_reset();
        cfg_valid = 1'b1;
        cfg_div   = 16'd5;
        step();
        cfg_valid = 1'b0;
        cfg_div   = 16'd0;
        checks++;
        if ({cur_div, cfg_ready, running} !== {16'd5, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL div5_stopped_write: got div=%0d rdy=%b run=%b required div=5 rdy=1 run=0",
                     cur_div, cfg_ready, running);
        end
        enable = 1'b1;
        step();
        for (int k = 0; k < 15; k++) begin
            exp = {1'b1, (k % 5) == 4, (k % 5) < 2};
            checks++;
            if ({running, tick, clk_out} !== exp) begin
                errors++;
                $display("FAIL div5_wave k=%0d: got %b required %b", k, {running, tick, clk_out}, exp);
            end
            step();
        end
    endtask

    task automatic test_ratio_change();
        logic [3:0] exp;
        do_reset();
        enable = 1'b1;
        step();
        for (int k = 0; k < 30; k++) step();
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL change_ready_before: got %b required 1", cfg_ready);
        end
        cfg_valid = 1'b1;
        cfg_div   = 16'd10;
        step();
        cfg_valid = 1'b0;
        cfg_div   = 16'd0;
        for (int ph = 31; ph < 100; ph++) begin
            exp = {1'b1, ph == 99, ph < 50, 1'b0};
            checks++;
            if ({running, tick, clk_out, cfg_ready} !== exp || cur_div !== 16'd100) begin
                errors++;
                $display("FAIL change_old_period ph=%0d: got %b div=%0d required %b div=100",
                         ph, {running, tick, clk_out, cfg_ready}, cur_div, exp);
            end
            step();
        end
        for (int k = 0; k < 30; k++) begin
            exp = {1'b1, (k % 10) == 9, (k % 10) < 5, 1'b1};
            checks++;
            if ({running, tick, clk_out, cfg_ready} !== exp || cur_div !== 16'd10) begin
                errors++;
                $display("FAIL change_new_period k=%0d: got %b div=%0d required %b div=10",
                         k, {running, tick, clk_out, cfg_ready}, cur_div, exp);
            end
            step();
        end
    endtask

    task automatic test_cfg_err();
        logic [2:0] exp;
        do_reset();
        enable = 1'b1;
        step();
        cfg_valid = 1'b1;
        cfg_div   = 16'd1;
        checks++;
        if (cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL err_idle: got %b required 0", cfg_err);
        end
        step();
        cfg_div = 16'd0;
        checks++;
        if ({cfg_err, cfg_ready} !== 2'b11) begin
            errors++;
            $display("FAIL err_first_pulse: got err/rdy %b required 11", {cfg_err, cfg_ready});
        end
        step();
        cfg_valid = 1'b0;
        checks++;
        if ({cfg_err, cfg_ready} !== 2'b11) begin
            errors++;
            $display("FAIL err_second_pulse: got err/rdy %b required 11", {cfg_err, cfg_ready});
        end
        step();
        checks++;
        if ({cfg_err, cfg_ready, cur_div} !== {1'b0, 1'b1, 16'd100}) begin
            errors++;
            $display("FAIL err_after: got err=%b rdy=%b div=%0d required err=0 rdy=1 div=100",
                     cfg_err, cfg_ready, cur_div);
        end
        for (int ph = 3; ph < 200; ph++) begin
            exp = {1'b1, (ph % 100) == 99, (ph % 100) < 50};
            checks++;
            if ({running, tick, clk_out} !== exp) begin
                errors++;
                $display("FAIL err_wave ph=%0d: got %b required %b", ph, {running, tick, clk_out}, exp);
            end
            step();
        end
    endtask

    task automatic test_drain();
        do_reset();
        enable = 1'b1;
        step();
        for (int k = 0; k < 40; k++) step();
        enable = 1'b0;
        for (int ph = 40; ph < 100; ph++) begin
            checks++;
            if ({running, tick} !== {1'b1, ph == 99}) begin
                errors++;
                $display("FAIL drain_wave ph=%0d: got run/tick %b required %b", ph, {running, tick}, {1'b1, ph == 99});
            end
            step();
        end
        checks++;
        if ({running, tick, clk_out} !== 3'b000) begin
            errors++;
            $display("FAIL drain_stopped: got %b required 000", {running, tick, clk_out});
        end
    endtask

    task automatic test_drain_resume();
        logic [1:0] exp;
        do_reset();
        enable = 1'b1;
        step();
        for (int k = 0; k < 40; k++) step();
        enable = 1'b0;
        for (int k = 40; k < 70; k++) step();
        enable = 1'b1;
        for (int ph = 70; ph < 300; ph++) begin
            exp = {1'b1, (ph % 100) == 99};
            checks++;
            if ({running, tick} !== exp) begin
                errors++;
                $display("FAIL resume_wave ph=%0d: got run/tick %b required %b", ph, {running, tick}, exp);
            end
            step();
        end
    endtask

    task automatic test_boundary_transfer();
        logic [3:0] exp;
        do_reset();
        cfg_valid = 1'b1;
        cfg_div   = 16'd5;
        enable    = 1'b1;
        step();
        cfg_valid = 1'b0;
        for (int k = 0; k < 4; k++) step();
        checks++;
        if (tick !== 1'b1) begin
            errors++;
            $display("FAIL bnd_tick_cycle: got %b required 1", tick);
        end
        cfg_valid = 1'b1;
        cfg_div   = 16'd3;
        step();
        cfg_valid = 1'b0;
        cfg_div   = 16'd0;
        for (int k = 0; k < 5; k++) begin
            exp = {k == 4, k < 2, 1'b0, 1'b1};
            checks++;
            if ({tick, clk_out, cfg_ready, running} !== exp || cur_div !== 16'd5) begin
                errors++;
                $display("FAIL bnd_old_period k=%0d: got %b div=%0d required %b div=5",
                         k, {tick, clk_out, cfg_ready, running}, cur_div, exp);
            end
            step();
        end
        for (int k = 0; k < 6; k++) begin
            exp = {(k % 3) == 2, (k % 3) < 1, 1'b1, 1'b1};
            checks++;
            if ({tick, clk_out, cfg_ready, running} !== exp || cur_div !== 16'd3) begin
                errors++;
                $display("FAIL bnd_new_period k=%0d: got %b div=%0d required %b div=3",
                         k, {tick, clk_out, cfg_ready, running}, cur_div, exp);
            end
            step();
        end
    endtask

    task automatic test_stop_with_pending();
        do_reset();
        enable = 1'b1;
        step();
        for (int k = 0; k < 10; k++) step();
        cfg_valid = 1'b1;
        cfg_div   = 16'd7;
        enable    = 1'b0;
        step();
        cfg_valid = 1'b0;
        cfg_div   = 16'd0;
        for (int ph = 11; ph < 100; ph++) step();
        checks++;
        if ({running, cfg_ready, cur_div} !== {1'b0, 1'b1, 16'd7}) begin
            errors++;
            $display("FAIL stop_pending: got run=%b rdy=%b div=%0d required run=0 rdy=1 div=7",
                     running, cfg_ready, cur_div);
        end
    endtask

    task automatic test_reset_pending();
        do_reset();
        enable = 1'b1;
        step();
        for (int k = 0; k < 20; k++) step();
        cfg_valid = 1'b1;
        cfg_div   = 16'd20;
        step();
        cfg_valid = 1'b0;
        cfg_div   = 16'd0;
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstp_pending_ready: got %b required 0", cfg_ready);
        end
        for (int k = 0; k < 10; k++) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        checks++;
        if ({tick, clk_out, running, cfg_err, cfg_ready, cur_div} !== {5'b00001, 16'd100}) begin
            errors++;
            $display("FAIL rstp_outputs: got %b div=%0d required 00001 div=100",
                     {tick, clk_out, running, cfg_err, cfg_ready}, cur_div);
        end
        step();
        for (int k = 0; k < 120; k++) begin
            checks++;
            if ({running, tick} !== {1'b1, k == 99}) begin
                errors++;
                $display("FAIL rstp_period k=%0d: got run/tick %b required %b", k, {running, tick}, {1'b1, k == 99});
            end
            step();
        end
    endtask

    initial begin
        step();
        test_reset();
        test_default_run();
        test_div5();
        test_ratio_change();
        test_cfg_err();
        test_drain();
        test_drain_resume();
        test_boundary_transfer();
        test_stop_with_pending();
        test_reset_pending();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
